if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and drives a single-outstanding request/acknowledge instruction-memory port. Returned instructions are buffered with their PCs in a 2-entry queue, which decouples memory latency from pipeline stalls. The stage presents one instruction per cycle to IF/ID and honours stall and branch-redirect requests from the hazard and execute logic.

## Interface
- PC_WIDTH, 32, width of all program-counter values
- INSTR_WIDTH, 64, instruction word width; matches the IF/ID instruction input
- RESET_PC, 0, first fetch address after reset
- PC_STEP, 8, byte increment per sequential fetch; power of two
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  downstream not accepting; head entry is held, not consumed
- redirect  in  1  branch/jump taken; flushes the stage
- redirect_pc  in  PC_WIDTH  new fetch target, sampled when redirect=1
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_WIDTH  fetch address, stable while imem_req=1
- imem_ack  in  1  memory response; imem_rdata is valid in the same cycle
- imem_rdata  in  INSTR_WIDTH  fetched instruction
- instr_valid  out  1  instr_out/pc_out hold a valid instruction
- instr_out  out  INSTR_WIDTH  instruction to IF/ID
- pc_out  out  PC_WIDTH  PC of instr_out

## Operation
- Queue: 2 entries of {pc, instr}. Tracked by a count of 0..2 plus head and tail pointers that wrap modulo 2.
- Outputs come from the queue head:
  - instr_valid = (count != 0).
  - When the queue is empty, instr_out and pc_out are 0.
- Pop condition: instr_valid && !stall && !redirect.
- Push condition: imem_ack while in FETCH state with no redirect in the same cycle. Push and pop in the same cycle leave count unchanged.
- Alignment: redirect_pc has its low log2(PC_STEP) bits forced to 0.
- State FETCH:
  - imem_req = 1 when count < 2. Only one request is ever outstanding.
  - Once raised, imem_req and imem_addr stay unchanged until imem_ack. Count cannot grow while waiting, so the request never has to be withdrawn.
  - On imem_ack: push {fetch_pc, imem_rdata} and set fetch_pc += PC_STEP. The addition wraps modulo 2^PC_WIDTH.
- State DISCARD:
  - Entered when redirect=1 while imem_req=1 and imem_ack=0.
  - imem_req stays 1 with the old address until imem_ack. The returned data is dropped.
  - On imem_ack, the next state is FETCH with fetch_pc = the latched target.
- Redirect, in any state:
  - Queue is flushed (count=0) in the same edge.
  - Target is latched. If no request is pending, or imem_ack arrives in the redirect cycle, fetch_pc is loaded directly, the response (if any) is dropped, and the stage stays in or returns to FETCH.
  - A redirect while in DISCARD overwrites the latched target. The last redirect wins.
- Priority: reset > redirect > stall.
- Stall never blocks fetching. The queue keeps filling up to 2 entries during a stall.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, instr_out=0, pc_out=0
  - count=0, fetch_pc=RESET_PC, state=FETCH
- First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
- Latency: a push at edge N makes the entry visible at instr_out in the cycle after N.
  - With zero-wait-state memory (ack in the request cycle), sustained throughput is 1 instruction per cycle.
- instr_out and pc_out come from registered storage. There is no combinational path from imem_rdata to them.
- Flush is visible in the cycle after redirect: instr_valid=0.
  - The first redirected instruction appears no earlier than 2 cycles after redirect.
  - In DISCARD, it appears 1 cycle after the redirected request is acknowledged.
- Reset asserted mid-transaction:
  - All state returns to reset values immediately.
  - imem_req drops asynchronously.
  - The memory side must discard the in-flight access.

## Test plan
- Zero-wait memory, no stall, after reset -> pc_out sequence 0x0, 0x8, 0x10, 0x18 on consecutive cycles starting 2 cycles after reset release; instr_valid stays 1.
- stall=1 for 5 cycles from steady state -> queue fills (count=2), imem_req drops to 0, and instr_out/pc_out hold constant. On release, both held entries then new fetches appear in order with no gap and no duplicate.
- Memory acks 3 cycles after req, with redirect_pc=0x100 pulsed in the 2nd wait cycle:
  - imem_addr stays at the old value until ack, and that data never appears at instr_out.
  - Next request is 0x100, and pc_out=0x100 is the first valid output.
- Redirect and imem_ack in the same cycle, redirect_pc=0x207 -> response dropped, next imem_addr=0x200, queue empty next cycle.
- Two redirects (0x40, then 0x80) while in DISCARD -> only 0x80 is fetched after the ack.
- Reset asserted while imem_req=1 with fetch_pc=0x38 -> imem_req=0 and instr_valid=0 immediately. After release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a single-outstanding
// req/ack instruction-memory port and buffers returned instructions with
// their PCs in a 2-entry queue feeding the IF/ID register.
module if_fetch_stage #(
  parameter int unsigned            PC_WIDTH    = 32,
  parameter int unsigned            INSTR_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter int unsigned            PC_STEP     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out
);

  localparam int unsigned         ALIGN_BITS = $clog2(PC_STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {PC_WIDTH{1'b1}} << ALIGN_BITS;
  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);

  typedef enum logic {
    S_FETCH,
    S_DISCARD
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]    target_q, target_d;
  logic [1:0]             count_q, count_d;
  logic                   head_q, head_d;
  logic                   tail_q, tail_d;
  logic [PC_WIDTH-1:0]    q_pc_q    [2];
  logic [INSTR_WIDTH-1:0] q_instr_q [2];

  logic                   req_int;
  logic                   push;
  logic                   pop;
  logic [PC_WIDTH-1:0]    redirect_aligned;

  // Request is held through DISCARD so the stale access can complete;
  // in FETCH it is raised only while the queue has room.
  assign req_int          = (state_q == S_DISCARD) || (count_q != 2'd2);
  assign imem_req         = req_int && !reset;
  assign imem_addr        = fetch_pc_q;
  assign redirect_aligned = redirect_pc & ALIGN_MASK;

  assign instr_valid = (count_q != 2'd0);
  assign instr_out   = instr_valid ? q_instr_q[head_q] : '0;
  assign pc_out      = instr_valid ? q_pc_q[head_q]    : '0;

  assign push = (state_q == S_FETCH) && req_int && imem_ack && !redirect;
  assign pop  = instr_valid && !stall && !redirect;

  // Next-state: redirect flushes and retargets; otherwise advance fetch PC
  // and queue occupancy.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redirect) begin
      count_d  = 2'd0;
      head_d   = 1'b0;
      tail_d   = 1'b0;
      target_d = redirect_aligned;
      // A pending access that is not completing now must be allowed to
      // finish with its old address; its data is dropped in DISCARD.
      if (!req_int || imem_ack) begin
        fetch_pc_d = redirect_aligned;
        state_d    = S_FETCH;
      end else begin
        state_d    = S_DISCARD;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (req_int && imem_ack) begin
            fetch_pc_d = fetch_pc_q + STEP;
          end
        end
        S_DISCARD: begin
          if (imem_ack) begin
            fetch_pc_d = target_q;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase

      if (push) begin
        tail_d = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue storage: write the acknowledged instruction at the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else if (push) begin
      q_pc_q[tail_q]    <= fetch_pc_q;
      q_instr_q[tail_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: memory responder with variable
// latency plus a scoreboard of expected {pc, instr} entries.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [63:0] imem_rdata;
  logic        instr_valid;
  logic [63:0] instr_out;
  logic [31:0] pc_out;

  if_fetch_stage #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (64),
    .RESET_PC    (32'h0),
    .PC_STEP     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out)
  );

  typedef struct {
    logic [31:0] pc;
    logic [63:0] instr;
  } entry_t;

  entry_t      sb_q[$];
  int unsigned errors;
  int unsigned checks;

  int unsigned mem_lat;
  int unsigned wait_cnt;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_target;
  logic        model_discard;
  logic        found;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a + 32'h1234_5678};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    pend          = 1'b0;
    wait_cnt      = 0;
    exp_pc        = 32'h0;
    exp_target    = 32'h0;
    model_discard = 1'b0;
  endtask

  // One clock cycle: entered at posedge+1, leaves at the next posedge+1.
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    logic        ack;
    logic        exp_req;
    logic [31:0] rpc_al;
    entry_t      e;
    ack     = 1'b0;
    exp_req = model_discard || (sb_q.size() < 2);
    check("req", imem_req, exp_req);
    check("valid", instr_valid, sb_q.size() != 0);
    if (sb_q.size() == 0) begin
      check("empty_pc", pc_out, 0);
      check("empty_instr", instr_out, 0);
    end
    if (imem_req) begin
      if (!pend) begin
        pend      = 1'b1;
        pend_addr = imem_addr;
        wait_cnt  = 0;
        check("req_addr", imem_addr, exp_pc);
      end else begin
        check("addr_hold", imem_addr, pend_addr);
      end
      ack = (wait_cnt == mem_lat);
      wait_cnt++;
    end else if (pend) begin
      check("req_withdrawn", imem_req, 1);
      pend = 1'b0;
    end

    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = ack ? data_of(imem_addr) : {$urandom(), $urandom()};

    if (instr_valid && !st && !rd && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("pc_out", pc_out, e.pc);
      check("instr_out", instr_out, e.instr);
    end

    rpc_al = rpc & ~32'h7;
    if (rd) begin
      sb_q.delete();
      exp_target = rpc_al;
      if (!pend || ack) begin
        exp_pc        = rpc_al;
        model_discard = 1'b0;
      end else begin
        model_discard = 1'b1;
      end
    end else if (ack) begin
      if (model_discard) begin
        model_discard = 1'b0;
        exp_pc        = exp_target;
      end else begin
        sb_q.push_back('{pc: exp_pc, instr: data_of(exp_pc)});
        exp_pc = exp_pc + 32'd8;
      end
    end
    if (ack) pend = 1'b0;

    @(posedge clk);
    #1;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    mem_lat     = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr_out, 0);
    check("rst_pc", pc_out, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait streaming.
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 0);
    tick(1'b0, 1'b0, 32'h0);
    check("first_valid", instr_valid, 1);
    check("first_pc", pc_out, 0);
    repeat (10) tick(1'b0, 1'b0, 32'h0);

    // Stall for 5 cycles: queue fills, head held.
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_pc", pc_out, sb_q[0].pc);
      check("stall_hold_instr", instr_out, sb_q[0].instr);
      tick(1'b1, 1'b0, 32'h0);
    end
    check("stall_req_low", imem_req, 0);
    check("stall_full", sb_q.size(), 2);
    repeat (8) tick(1'b0, 1'b0, 32'h0);

    // 3-cycle memory, redirect to 0x100 in the 2nd wait cycle.
    mem_lat = 3;
    found   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pend && wait_cnt == 2) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
    check("tmo_wait2", found, 1);
    tick(1'b0, 1'b1, 32'h100);
    check("flush_valid", instr_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
    check("tmo_redir100", found, 1);
    check("redir100_pc", pc_out, 32'h100);
    repeat (6) tick(1'b0, 1'b0, 32'h0);

    // Redirect coinciding with ack, unaligned target 0x207.
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pend && wait_cnt == mem_lat) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
    check("tmo_ackcycle", found, 1);
    tick(1'b0, 1'b1, 32'h207);
    check("redir_ack_addr", imem_addr, 32'h200);
    check("redir_ack_req", imem_req, 1);
    check("redir_ack_valid", instr_valid, 0);
    repeat (8) tick(1'b0, 1'b0, 32'h0);

    // Two redirects while in DISCARD: last one wins.
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pend && wait_cnt == 1) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
    check("tmo_wait1", found, 1);
    tick(1'b0, 1'b1, 32'h40);
    tick(1'b0, 1'b1, 32'h80);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
    check("tmo_redir80", found, 1);
    check("redir80_pc", pc_out, 32'h80);
    repeat (6) tick(1'b0, 1'b0, 32'h0);

    // Random mix of latency, stall and redirect.
    for (int i = 0; i < 120; i++) begin
      if (!pend) mem_lat = $urandom_range(0, 2);
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom());
    end

    // Reset in the middle of a request at 0x38.
    mem_lat = 1;
    tick(1'b0, 1'b1, 32'h30);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req && imem_addr == 32'h38 && instr_valid) begin
        found = 1'b1;
        break;
      end
      tick(1'b1, 1'b0, 32'h0);
    end
    check("tmo_pc38", found, 1);
    reset    = 1'b1;
    imem_ack = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    #1;
    check("midrst_req", imem_req, 0);
    check("midrst_valid", instr_valid, 0);
    check("midrst_addr", imem_addr, 0);
    check("midrst_pc", pc_out, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mem_lat = 0;
    check("restart_addr", imem_addr, 0);
    repeat (8) tick(1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
